nios_fprint_mem_scanner: RTL and testbench

NIOS_FPRINT_MEM_SCANNER -- requirements
Module: nios_fprint_mem_scanner

---
 rtl/nios_fprint_pkg.sv | 21 ++
 rtl/nios_fprint_rd_pipe.sv | 30 +++
 rtl/nios_fprint_mem_scanner.sv | 118 +++++++++++
 tb/tb_nios_fprint_mem_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_fprint_pkg.sv
// Shared definitions for the memory fingerprint scanner: FSM encoding,
// fingerprint seed and the rotate-XOR accumulation step.
package nios_fprint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [31:0] FP_SEED     = 32'h0;
  localparam logic [3:0]  BYTE_EN_ALL = 4'hF;

  // Rotate the running fingerprint left by one, then fold in the new word.
  function automatic logic [31:0] fp_update(input logic [31:0] fp,
                                            input logic [31:0] word);
    return {fp[30:0], fp[31]} ^ word;
  endfunction

endpackage

// File: rtl/nios_fprint_rd_pipe.sv
// Valid shift register that marks which cycles carry read data, one bit
// per cycle of fixed slave read latency.
module nios_fprint_rd_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic acc_i,
  output logic tail_o
);

  logic [LATENCY-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = acc_i;
  end

  // Cleared on reset so data from reads issued before reset is never consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tail_o = vld_q[LATENCY-1];

endmodule

// File: rtl/nios_fprint_mem_scanner.sv
// Avalon-MM read master that streams a block of words and folds them into a
// 32-bit rotate-XOR fingerprint.
module nios_fprint_mem_scanner
  import nios_fprint_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [31:0]       fingerprint,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              read,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [ADDR_W-1:0] issue_q, issue_d;
  logic [ADDR_W-1:0] ret_q, ret_d, ret_next;
  logic [31:0]       fp_q, fp_d;
  logic              start_acc, rd_acc, last_issue, tail, consume;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign rd_acc     = read && !waitrequest;
  assign last_issue = rd_acc && ((issue_q + ADDR_W'(1)) == len_q);
  // Returns are only meaningful while a scan is in flight.
  assign consume    = tail && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign ret_next   = ret_q + ADDR_W'(consume);

  nios_fprint_rd_pipe #(
    .LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .acc_i  (rd_acc),
    .tail_o (tail)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (length == '0) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_next == len_q) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read       = (state_q == ST_ISSUE);
    chipselect = (state_q == ST_ISSUE);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_FINISH);
    address    = (state_q == ST_ISSUE) ? (base_q + issue_q) : '0;
    byteenable = BYTE_EN_ALL;
  end

  // An issue accept and a data return in the same cycle are both applied.
  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_next;
    fp_d    = fp_q;
    if (start_acc) begin
      issue_d = '0;
      ret_d   = '0;
      fp_d    = FP_SEED;
    end else begin
      if (rd_acc)  issue_d = issue_q + ADDR_W'(1);
      if (consume) fp_d    = fp_update(fp_q, readdata);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q <= '0;
      ret_q   <= '0;
      fp_q    <= FP_SEED;
    end else begin
      issue_q <= issue_d;
      ret_q   <= ret_d;
      fp_q    <= fp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      base_q <= base_addr;
      len_q  <= length;
    end
  end

  assign fingerprint = fp_q;

endmodule

// File: tb/tb_nios_fprint_mem_scanner.sv
// Bench for the memory fingerprint scanner: on-chip RAM style slave model,
// directed corner cases and randomized scans against a reference fingerprint.
module tb_nios_fprint_mem_scanner;

  localparam int RL = 1;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, chipselect, read;
  logic [31:0]   fingerprint, readdata;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          waitrequest = 1'b0;

  always #5 clk = ~clk;

  nios_fprint_mem_scanner #(
    .READ_LATENCY(RL),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .fingerprint(fingerprint),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .byteenable (byteenable),
    .waitrequest(waitrequest),
    .readdata   (readdata)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0]   ovr [int unsigned];
  logic [31:0]   salt = 32'h0;
  int            stall_mode = 0;
  logic [AW-1:0] addr_log [$];
  int            read_cycles = 0;
  int            hold_viol = 0;
  logic [31:0]   dq [RL];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (ovr.exists(32'(a))) return ovr[32'(a)];
    return (32'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  // Reference fingerprint: rotate-left-by-one then XOR, over consecutive words.
  function automatic logic [31:0] model_fp(input logic [AW-1:0] b, input int n);
    logic [31:0] fp = 32'h0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = mem_word(b + AW'(i));
      fp = ((fp << 1) | (fp >> 31)) ^ w;
    end
    return fp;
  endfunction

  // Slave: fixed latency, garbage on the bus whenever no data is due.
  always @(posedge clk) begin
    if (read && !waitrequest) addr_log.push_back(address);
    for (int i = RL - 1; i > 0; i--) dq[i] <= dq[i-1];
    dq[0] <= (read && !waitrequest) ? mem_word(address) : $urandom;
  end
  assign readdata = dq[RL-1];

  // Stall generator and hold monitor, sampled mid-cycle.
  initial begin
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && !(read && (address == prev_addr))) hold_viol++;
      if (!busy) stall_cnt = 0;
      if (stall_mode == 1) begin
        waitrequest = ($urandom_range(0, 2) == 0);
      end else if (stall_mode == 2 && read && stall_cnt < 3) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
      end
      prev_stall = read && waitrequest;
      prev_addr  = address;
      if (read) read_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns cycles from the start edge to done.
  task automatic run_scan(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input bit mid_start, output int cyc, output logic [31:0] fp);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = AW'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", 32'(busy), 32'd1);
      if (mid_start && cyc == 2) begin
        start     = 1'b1;
        base_addr = '0;
        length    = '0;
      end
      if (cyc == 3) start = 1'b0;
    end while (!done && cyc < 300);
    start = 1'b0;
    fp = fingerprint;
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_low_after", 32'(busy), 32'd0);
    chk("fp_held", fingerprint, fp);
  endtask

  task automatic scan_check(input string name, input logic [AW-1:0] b, input int n,
                            input bit check_time, input bit mid_start);
    int          li = addr_log.size();
    int          cyc, bad;
    logic [31:0] fp;
    run_scan(b, AW'(n), mid_start, cyc, fp);
    chk({name, "_nreads"}, 32'(addr_log.size() - li), 32'(n));
    bad = 0;
    for (int i = 0; i < n && (li + i) < addr_log.size(); i++)
      if (addr_log[li+i] !== b + AW'(i)) bad++;
    chk({name, "_addr_seq"}, 32'(bad), 32'd0);
    chk({name, "_fp"}, fp, model_fp(b, n));
    if (check_time) chk({name, "_latency"}, 32'(cyc), 32'(n + RL + 1));
  endtask

  initial begin
    int          li, rc0, hv0, cyc, guard;
    logic [31:0] fp;
    logic [AW-1:0] b;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_cs", 32'(chipselect), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_fp", fingerprint, 32'd0);
    chk("byteenable", 32'(byteenable), 32'hF);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-word scan whose words cancel out.
    ovr[32'h100] = 32'h1;
    ovr[32'h101] = 32'h2;
    li = addr_log.size();
    run_scan(18'h100, 18'd2, 1'b0, cyc, fp);
    chk("basic_addr0", 32'(addr_log[li]), 32'h100);
    chk("basic_addr1", 32'(addr_log[li+1]), 32'h101);
    chk("basic_fp", fp, 32'h0);
    chk("basic_latency", 32'(cyc), 32'd4);

    // Zero-length scan never touches the bus.
    rc0 = read_cycles;
    run_scan(18'h55, 18'd0, 1'b0, cyc, fp);
    chk("len0_reads", 32'(read_cycles - rc0), 32'd0);
    chk("len0_latency", 32'(cyc), 32'd1);
    chk("len0_fp", fp, 32'h0);

    // MSB rotates into bit 0.
    ovr[32'h200] = 32'h8000_0000;
    ovr[32'h201] = 32'h0;
    run_scan(18'h200, 18'd2, 1'b0, cyc, fp);
    chk("rot_fp", fp, 32'h1);

    // Address wraps silently at the top of the word space.
    li = addr_log.size();
    run_scan(18'h3FFFF, 18'd2, 1'b0, cyc, fp);
    chk("wrap_addr0", 32'(addr_log[li]), 32'h3FFFF);
    chk("wrap_addr1", 32'(addr_log[li+1]), 32'h0);
    chk("wrap_fp", fp, model_fp(18'h3FFFF, 2));

    // Three-cycle stall on the first read.
    stall_mode = 2;
    hv0 = hold_viol;
    run_scan(18'h100, 18'd2, 1'b0, cyc, fp);
    chk("stall_fp", fp, 32'h0);
    chk("stall_latency", 32'(cyc), 32'd7);
    chk("stall_hold", 32'(hold_viol - hv0), 32'd0);
    stall_mode = 0;

    // Start while busy is ignored.
    salt = $urandom;
    scan_check("midstart", 18'h300, 6, 1'b1, 1'b1);

    // Randomized scans with random back-pressure.
    ovr.delete();
    stall_mode = 1;
    hv0 = hold_viol;
    for (int t = 0; t < 8; t++) begin
      salt = $urandom;
      b = ($urandom_range(0, 3) == 0) ? AW'(18'h3FFFF - $urandom_range(0, 10)) : AW'($urandom);
      scan_check("rand_stall", b, $urandom_range(1, 24), 1'b0, 1'b0);
    end
    stall_mode = 0;
    @(negedge clk);
    chk("rand_hold", 32'(hold_viol - hv0), 32'd0);
    for (int t = 0; t < 4; t++) begin
      salt = $urandom;
      scan_check("rand_nostall", AW'($urandom), $urandom_range(1, 24), 1'b1, 1'b0);
    end

    // Reset while draining the last return.
    salt = $urandom;
    li = addr_log.size();
    base_addr = 18'h1234;
    length    = 18'd8;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((addr_log.size() - li) < 8 && guard < 100);
    chk("drain_reached", 32'(addr_log.size() - li), 32'd8);
    chk("drain_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_read", 32'(read), 32'd0);
    chk("mid_rst_cs", 32'(chipselect), 32'd0);
    chk("mid_rst_addr", 32'(address), 32'd0);
    chk("mid_rst_fp", fingerprint, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_fp", fingerprint, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    salt = $urandom;
    scan_check("post_rst", 18'h2000, 9, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
